// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: FSM/owner encodings and
// the default RAM geometry shared with the RAM and the matrix control unit.
package ram_port_arbiter_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 9;

    // State values double as the owner output encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the single-port data RAM (registered read).
// Port 0 is the host/loader, port 1 the matrix-multiply control unit.
// Ports:
//   clk, rst                  clock, async active-high reset
//   rN_req/lock/we/addr/wdata requester N command (N = 0, 1)
//   rN_gnt                    access accepted this cycle (combinational)
//   rN_rvalid                 read data for requester N on rdata
//   rdata                     shared read data, zero unless an rvalid is high
//   ram_addr/we/w_data        RAM command pins
//   ram_r_data                RAM read data, one cycle after the address
//   owner                     current owner (00 none, 01 port 0, 10 port 1)
//   hold_err                  sticky: a lock outlived 4*max_hold cycles
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned data_w   = DATA_W,
    parameter int unsigned addr_w   = ADDR_W,
    parameter int unsigned max_hold = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_lock,
    input  logic              r0_we,
    input  logic [addr_w-1:0] r0_addr,
    input  logic [data_w-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,

    input  logic              r1_req,
    input  logic              r1_lock,
    input  logic              r1_we,
    input  logic [addr_w-1:0] r1_addr,
    input  logic [data_w-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,

    output logic [data_w-1:0] rdata,

    output logic [addr_w-1:0] ram_addr,
    output logic              ram_we,
    output logic [data_w-1:0] ram_w_data,
    input  logic [data_w-1:0] ram_r_data,

    output logic [1:0]        owner,
    output logic              hold_err
);

    localparam int unsigned HOLD_W   = $clog2(max_hold + 1);
    localparam int unsigned LOCK_LIM = 4 * max_hold;
    localparam int unsigned LOCK_W   = $clog2(LOCK_LIM + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(max_hold - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(max_hold);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_LIM);

    arb_state_e        state_q, state_d;
    logic              rr_q, rr_d;          // 1 = port 1 preferred on a tie
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              err_q, err_d;
    logic              rv0_q, rv0_d;
    logic              rv1_q, rv1_d;

    logic own_req, own_lock, own_gnt, oth_req;

    // Grants and owner-relative views of the request lines.
    always_comb begin
        r0_gnt   = (state_q == ST_OWN0) & r0_req;
        r1_gnt   = (state_q == ST_OWN1) & r1_req;
        own_gnt  = r0_gnt | r1_gnt;
        own_req  = 1'b0;
        own_lock = 1'b0;
        oth_req  = 1'b0;
        if (state_q == ST_OWN0) begin
            own_req  = r0_req;
            own_lock = r0_lock;
            oth_req  = r1_req;
        end else if (state_q == ST_OWN1) begin
            own_req  = r1_req;
            own_lock = r1_lock;
            oth_req  = r0_req;
        end
    end

    // RAM pins follow the granted port and are parked at zero otherwise.
    always_comb begin
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_w_data = '0;
        if (r0_gnt) begin
            ram_we     = r0_we;
            ram_addr   = r0_addr;
            ram_w_data = r0_wdata;
        end else if (r1_gnt) begin
            ram_we     = r1_we;
            ram_addr   = r1_addr;
            ram_w_data = r1_wdata;
        end
    end

    // Next-state, round-robin pointer, hold/lock counters and read strobes.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        lock_d  = lock_q;
        err_d   = err_q;
        rv0_d   = r0_gnt & ~r0_we;
        rv1_d   = r1_gnt & ~r1_we;

        unique case (state_q)
            ST_IDLE: begin
                if (r0_req && r1_req) begin
                    state_d = rr_q ? ST_OWN1 : ST_OWN0;
                end else if (r0_req) begin
                    state_d = ST_OWN0;
                end else if (r1_req) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (own_lock) begin
                    state_d = state_q;
                end else if (!own_req) begin
                    if (oth_req) begin
                        state_d = (state_q == ST_OWN0) ? ST_OWN1 : ST_OWN0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (oth_req && own_gnt && (hold_q == HOLD_LAST)) begin
                    state_d = (state_q == ST_OWN0) ? ST_OWN1 : ST_OWN0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Leaving an owner hands tie priority to the other port.
        if ((state_q != ST_IDLE) && (state_d != state_q)) begin
            rr_d = (state_q == ST_OWN0);
        end

        // Fairness counter: only unlocked grants under contention count.
        if ((state_d != state_q) || !oth_req) begin
            hold_d = '0;
        end else if (own_gnt && !own_lock && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HOLD_W'(1);
        end

        // Lock watchdog: flags, but does not break, an overlong lock.
        if (own_lock) begin
            if (lock_q == LOCK_MAX) begin
                err_d = 1'b1;
            end else begin
                lock_d = lock_q + LOCK_W'(1);
            end
        end else begin
            lock_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            hold_q  <= '0;
            lock_q  <= '0;
            err_q   <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
        end
    end

    assign r0_rvalid = rv0_q;
    assign r1_rvalid = rv1_q;
    assign rdata     = (rv0_q | rv1_q) ? ram_r_data : '0;
    assign owner     = state_q;
    assign hold_err  = err_q;

endmodule
